// File: rtl/axi_ram_slave.sv
// axi_ram_slave
// -------------
// AXI3 responder backed by an internal word-addressed RAM, so the CPU-side
// AXI master can run without an external memory controller. Read and write
// channels have independent FSMs and accept one transaction each. Only 32-bit
// INCR bursts of 1..16 beats are supported. Writes use byte strobes.
//
// Parameters:
//   ADDR_W  word-address bits (RAM depth 2^ADDR_W words; byte addr [ADDR_W+1:2])
//   ID_W    width of the AXI ID fields
//   DELAY   ready-insertion cycles, used only when AXI_SLV_DELAY_EN is defined
//
// Optional feature macro: AXI_SLV_DELAY_EN
//   When defined, arready/awready stay low for DELAY cycles after each return
//   to idle (including after reset). The first rvalid of each burst also
//   arrives DELAY cycles later. When undefined, no delay counters exist.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   arid/araddr/arlen/arvalid/arready  read address channel
//   rid/rdata/rresp/rlast/rvalid/rready  read data channel
//   awid/awaddr/awlen/awvalid/awready  write address channel
//   wdata/wstrb/wlast/wvalid/wready    write data channel
//   bid/bresp/bvalid/bready            write response channel
//
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where valid and ready are both high. A source holds valid and its payload
// stable until that edge. Ready may change freely.
`timescale 1ns/1ps
module axi_ram_slave #(
    parameter int ADDR_W = 12,
    parameter int ID_W   = 4,
    parameter int DELAY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    typedef enum logic {R_IDLE, R_BURST} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    rstate_t rstate, rstate_nx;
    wstate_t wstate, wstate_nx;

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] rptr, wptr;
    logic [3:0]        rcnt, wcnt;
    logic              rerr, werr;
    logic [ID_W-1:0]   rid_q, bid_q;
    logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic              r_gate, aw_gate;

    // Address bits outside the word index carry no information for this RAM.
    logic unused_addr;
    assign unused_addr = ^{araddr[31:ADDR_W+2], araddr[1:0],
                           awaddr[31:ADDR_W+2], awaddr[1:0]};

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;

`ifdef AXI_SLV_DELAY_EN
    localparam logic [7:0] DLY = 8'(DELAY);
    logic [7:0] rdly, wdly;

    // The read counter serves two purposes. It delays the first beat after an
    // AR handshake, and it holds arready low after the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdly <= DLY;
            wdly <= DLY;
        end else begin
            if (ar_hs || (r_hs && rlast)) rdly <= DLY;
            else if (rdly != 8'd0)        rdly <= rdly - 8'd1;
            if (b_hs)                     wdly <= DLY;
            else if (wdly != 8'd0)        wdly <= wdly - 8'd1;
        end
    end
    assign r_gate  = (rdly == 8'd0);
    assign aw_gate = (wdly == 8'd0);
`else
    assign r_gate  = 1'b1;
    assign aw_gate = 1'b1;
`endif

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate <= R_IDLE;
            wstate <= W_IDLE;
        end else begin
            rstate <= rstate_nx;
            wstate <= wstate_nx;
        end
    end

    // Read FSM: next state and handshake outputs
    always_comb begin
        rstate_nx = rstate;
        arready   = 1'b0;
        rvalid    = 1'b0;
        case (rstate)
            R_IDLE: begin
                arready = r_gate & ~rst;
                if (arvalid && arready) rstate_nx = R_BURST;
            end
            R_BURST: begin
                rvalid = r_gate;
                if (rvalid && rready && (rcnt == 4'd0)) rstate_nx = R_IDLE;
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    // Write FSM: next state and handshake outputs
    always_comb begin
        wstate_nx = wstate;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (wstate)
            W_IDLE: begin
                awready = aw_gate & ~rst;
                if (awvalid && awready) wstate_nx = W_DATA;
            end
            W_DATA: begin
                wready = ~rst;
                if (wvalid && wready && (wlast || (wcnt == 4'd0))) wstate_nx = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    // Burst bookkeeping. The word pointers wrap naturally at 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            rcnt  <= '0;
            rerr  <= 1'b0;
            rid_q <= '0;
            wptr  <= '0;
            wcnt  <= '0;
            werr  <= 1'b0;
            bid_q <= '0;
        end else begin
            if (ar_hs) begin
                rid_q <= arid;
                rptr  <= araddr[ADDR_W+1:2];
                rcnt  <= arlen[3:0];
                rerr  <= |arlen[7:4];
            end else if (r_hs) begin
                rptr <= rptr + 1'b1;
                rcnt <= rcnt - 1'b1;
            end
            if (aw_hs) begin
                bid_q <= awid;
                wptr  <= awaddr[ADDR_W+1:2];
                wcnt  <= awlen[3:0];
                werr  <= |awlen[7:4];
            end else if (w_hs) begin
                wptr <= wptr + 1'b1;
                wcnt <= wcnt - 1'b1;
                // An early wlast or a missing wlast at the count end both flag SLVERR.
                if (wlast != (wcnt == 4'd0)) werr <= 1'b1;
            end
        end
    end

    // RAM write port. The RAM is not reset. The read is combinational, so a
    // read beat in the same cycle as a write to that word sees the old value.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[wptr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = rvalid ? mem[rptr] : 32'd0;
    assign rresp = (rvalid && rerr) ? 2'b10 : 2'b00;
    assign rlast = rvalid && (rcnt == 4'd0);
    assign rid   = rid_q;
    assign bresp = (bvalid && werr) ? 2'b10 : 2'b00;
    assign bid   = bid_q;

endmodule
